weight_fifo_ctrl: RTL
=====================

# weight_fifo_ctrl

Sequencer for the systolic array's weight path. On a start pulse it reads FIFO_STAGES weight rows from weight memory into the weight FIFO, one row per cycle. It then drains the FIFO into the array's weight-shift chain under a ready handshake and pulses done. It sits between the weight memory and the weight FIFO and drives the FIFO's shift enable and the array's weight-shift strobe.

## Interface

- FIFO_STAGES, 4, number of rows per load; equals the FIFO stage count; ≥1
- ADDR_WIDTH, 8, weight memory address width
- CNT_WIDTH, clog2(FIFO_STAGES+1), internal row counter width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces IDLE and all registered outputs to 0 immediately
- start  in  1  load request; sampled only while busy=0
- clear  in  1  synchronous abort; returns to IDLE next edge with no done pulse
- baseAddr  in  ADDR_WIDTH  address of first row; captured with start
- arrayReady  in  1  array can accept a weight shift this cycle
- memAddr  out  ADDR_WIDTH  weight memory read address (registered)
- memRd  out  1  weight memory read strobe (registered); memory returns data 1 cycle later onto FIFO weightIn
- fifoEn  out  1  weight FIFO shift enable
- weightShift  out  1  array weight-chain shift strobe
- busy  out  1  load/drain in progress (registered)
- done  out  1  one-cycle completion pulse (registered)

## Operation

- States: IDLE, FILL, FLUSH, DRAIN, DONE.
- IDLE: busy=0. When start=1, capture baseAddr, reset the counter to 0, and go to FILL.
- FILL:
  - Each cycle: memRd=1, memAddr=base+k for k=0..FIFO_STAGES-1.
  - fifoEn is asserted, registered, one cycle after each memRd, so each returned row is shifted in.
  - After FIFO_STAGES reads, go to FLUSH.
- FLUSH: a single cycle. memRd=0 and fifoEn=1 to accept the last row. Then go to DRAIN with the counter reset.
- DRAIN:
  - fifoEn = weightShift = arrayReady. This is combinational from arrayReady and is the only combinational output path.
  - The counter increments only on cycles with arrayReady=1.
  - After FIFO_STAGES accepted shifts, go to DONE.
  - arrayReady=0 stalls the drain indefinitely with no shift.
- DONE: a single cycle. done=1, busy=0, then go to IDLE. A start in this cycle is accepted as if the block were in IDLE (back-to-back loads).
- Address arithmetic is modulo 2^ADDR_WIDTH: base=0xFE, S=4 reads 0xFE, 0xFF, 0x00, 0x01.
- start while busy=1 is ignored; the new baseAddr is not captured.
- clear has priority over every transition, start included. All outputs are 0 the cycle after clear is sampled. FIFO contents are not scrubbed: the next load overwrites them fully.
- reset low mid-operation: IDLE immediately; memAddr=0; memRd, fifoEn, weightShift, busy, done all 0.

## Timing

- Reset values: all outputs 0, state IDLE, counter 0.
- Let start be sampled at edge E0, and number cycles after E0 as 1, 2, ….
  - Cycles 1..S: memRd=1, memAddr=base+(n-1).
  - Cycles 2..S+1: fifoEn=1. Cycle S+1 is FLUSH.
  - DRAIN begins at cycle S+2.
  - With arrayReady held 1: fifoEn=weightShift=1 on cycles S+2..2S+1, done=1 on cycle 2S+2.
- busy=1 on cycles 1..2S+1 plus any stall cycles. busy=0 in the done cycle.
- Every stalled cycle in DRAIN delays done by exactly one cycle.
- FILL/FLUSH latency is fixed at S+1 cycles and ignores arrayReady.
- memRd and fifoEn are never both 0 during FILL cycles 2..S.
- During FILL/FLUSH, weightShift=0.

## Test plan

- Reset: hold reset=0 for 3 cycles with start=1, then release. Required: all outputs 0 during reset, and no activity until start is sampled after release.
- Basic load, S=4, base=0x10, arrayReady=1:
  - memAddr 0x10..0x13 with memRd on cycles 1–4
  - fifoEn on cycles 2–5; weightShift on cycles 6–9
  - done on cycle 10; busy on cycles 1–9
  - A scoreboard confirms rows arrive at the array in order 0x10..0x13.
- Stall: as the basic load, but arrayReady=0 on cycles 6–8. Required: no fifoEn/weightShift on those cycles, four shifts on cycles 9–12, done on cycle 13.
- Wrap and back-to-back:
  - base=0xFE. Required: addresses 0xFE, 0xFF, 0x00, 0x01.
  - Assert start with base=0x40 in the done cycle. Required: memAddr=0x40 on the next cycle.
- Ignored start: pulse start with base=0x80 during FILL. Required: addresses continue from the original base, and exactly one done pulse.
- Aborts:
  - clear=1 in DRAIN cycle 7. Required: all outputs 0 on cycle 8, no done, IDLE.
  - reset=0 asynchronously mid-FILL. Required: outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/weight_fifo_ctrl_if.sv
// Purpose: handshake/bus bundle between the weight-path sequencer and its environment.
// Latency: none (wires only).
// Backpressure: arrayReady from the array side stalls the drain phase.
interface weight_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  clear;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic                  arrayReady;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memRd;
  logic                  fifoEn;
  logic                  weightShift;
  logic                  busy;
  logic                  done;

  // Requester / environment side
  modport master (
    output start, clear, baseAddr, arrayReady,
    input  memAddr, memRd, fifoEn, weightShift, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, clear, baseAddr, arrayReady,
    output memAddr, memRd, fifoEn, weightShift, busy, done
  );
endinterface

// File: rtl/weight_fifo_ctrl.sv
// Purpose: loads FIFO_STAGES weight rows from memory into the weight FIFO, then drains them into the array.
// Latency: fill+flush fixed at FIFO_STAGES+1 cycles; drain FIFO_STAGES accepted shifts; done one cycle later.
// Backpressure: arrayReady=0 stalls the drain (no shift) indefinitely; fill ignores arrayReady.
module weight_fifo_ctrl #(
  parameter int FIFO_STAGES = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = $clog2(FIFO_STAGES + 1)
) (
  input logic               clk,
  input logic               reset,
  weight_fifo_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FIFO_STAGES - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  rd_q,    rd_d;
  logic                  fen_q,   fen_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  shift_now;

  // Next-state and registered-output decode; clear overrides every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    rd_d    = 1'b0;
    fen_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        // DONE behaves like IDLE so a start in the done cycle chains loads
        IDLE, DONE: begin
          busy_d = 1'b0;
          if (bus.start) begin
            state_d = FILL;
            cnt_d   = '0;
            addr_d  = bus.baseAddr;
            rd_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        // Every FILL cycle issues a read, so the row it returns is shifted in next cycle
        FILL: begin
          fen_d = 1'b1;
          if (cnt_q == LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = addr_q + 1'b1;
            rd_d   = 1'b1;
          end
        end
        FLUSH: begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
        DRAIN: begin
          if (bus.arrayReady) begin
            if (cnt_q == LAST) begin
              state_d = DONE;
              cnt_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; async reset forces IDLE with all outputs low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      fen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      fen_q   <= fen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Drain shifts follow arrayReady combinationally; the only unregistered output path
  assign shift_now       = (state_q == DRAIN) && bus.arrayReady;
  assign bus.weightShift = shift_now;
  assign bus.fifoEn      = fen_q | shift_now;
  assign bus.memAddr     = addr_q;
  assign bus.memRd       = rd_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
